// File: rtl/sequence_player.sv
// Simon colour-sequence playback engine: walks the sequence RAM and
// flashes each stored colour on the one-hot button lamps.
module sequence_player #(
    parameter int MAX_LEN    = 32,
    parameter int ADDR_W     = 5,
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_data,
    output logic [3:0]        led,
    output logic              busy,
    output logic              done
);

    localparam int LW      = ADDR_W + 1;
    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [LW-1:0] LEN_CAP  = LW'(MAX_LEN);
    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [LW-1:0]     len_q, len_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        colour_q, colour_d;
    logic              zwait_q, zwait_d;
    logic [ADDR_W-1:0] addr_d;
    logic [3:0]        led_d;
    logic              busy_d;
    logic              done_d;
    logic [LW-1:0]     idx_inc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            colour_q <= '0;
            zwait_q  <= 1'b0;
            mem_addr <= '0;
            led      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            colour_q <= colour_d;
            zwait_q  <= zwait_d;
            mem_addr <= addr_d;
            led      <= led_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        colour_d = colour_q;
        zwait_d  = zwait_q;
        addr_d   = mem_addr;
        idx_inc  = {1'b0, idx_q} + LW'(1);

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    len_d = (length > LEN_CAP) ? LEN_CAP : length;
                    idx_d = '0;
                    if (len_d == '0) begin
                        // Empty playback spends one silent busy cycle before done
                        state_d = S_DONE;
                        zwait_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        addr_d  = '0;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                colour_d = mem_data;
                cnt_d    = ON_LOAD;
                state_d  = S_ON;
            end
            S_ON: begin
                if (cnt_q == '0) begin
                    cnt_d   = OFF_LOAD;
                    state_d = S_OFF;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_OFF: begin
                if (cnt_q == '0) begin
                    if (idx_inc == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        addr_d  = idx_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (zwait_q) begin
                    zwait_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            zwait_d = 1'b0;
        end

        // Outputs are registered from the next state so they align with it
        led_d  = (state_d == S_ON) ? (4'b0001 << colour_d) : 4'b0000;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE) && !zwait_d;
    end

endmodule

// File: tb/tb_sequence_player.sv
// Directed, table-driven bench for sequence_player with short
// lamp timings and a one-cycle-latency sequence RAM model.
module tb_sequence_player;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       start  = 1'b0;
    logic       abort  = 1'b0;
    logic [5:0] length = '0;
    logic [4:0] mem_addr;
    logic [1:0] mem_data;
    logic [3:0] led;
    logic       busy;
    logic       done;

    logic [1:0] ram [0:31];
    int errors = 0;
    int checks = 0;

    sequence_player #(
        .MAX_LEN   (32),
        .ADDR_W    (5),
        .ON_CYCLES (4),
        .OFF_CYCLES(2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .length  (length),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .led     (led),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    always_ff @(posedge clock) mem_data <= ram[mem_addr];

    typedef struct {
        logic       start;
        logic [5:0] length;
        logic [3:0] led;
        logic       busy;
        logic       done;
        logic [4:0] addr;
    } vec_t;

    vec_t vecs [26];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] oh(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    task automatic chk_all(input string tag, input logic [3:0] e_led,
                           input logic e_busy, input logic e_done);
        chk({tag, " led"}, 32'(led), 32'(e_led));
        chk({tag, " busy"}, 32'(busy), 32'(e_busy));
        chk({tag, " done"}, 32'(done), 32'(e_done));
    endtask

    initial begin
        logic [1:0] c2 [3];
        int done_cnt;
        c2[0] = 2'b10;
        c2[1] = 2'b00;
        c2[2] = 2'b11;
        for (int i = 0; i < 32; i++) ram[i] = '0;
        ram[0] = c2[0];
        ram[1] = c2[1];
        ram[2] = c2[2];

        for (int j = 0; j < 26; j++) begin
            int e;
            int p;
            e = j / 8;
            p = j % 8;
            vecs[j].start  = (j == 3 || j == 10 || j == 20 || j == 24);
            vecs[j].length = (j >= 1 && j <= 23) ? 6'd7 : 6'd3;
            if (j < 24) begin
                vecs[j].led  = (p >= 2 && p <= 5) ? oh(c2[e]) : 4'b0000;
                vecs[j].busy = 1'b1;
                vecs[j].done = 1'b0;
                vecs[j].addr = 5'(e);
            end else begin
                vecs[j].led  = 4'b0000;
                vecs[j].busy = (j == 24);
                vecs[j].done = (j == 24);
                vecs[j].addr = 5'd2;
            end
        end

        #12;
        chk_all("por", 4'b0000, 1'b0, 1'b0);
        chk("por addr", 32'(mem_addr), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Asynchronous reset in the middle of the second ON phase
        start  = 1'b1;
        length = 6'd3;
        step();
        start = 1'b0;
        for (int j = 1; j <= 10; j++) step();
        chk("t1 pre led", 32'(led), 32'(oh(c2[1])));
        chk("t1 pre addr", 32'(mem_addr), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk_all("t1 rst", 4'b0000, 1'b0, 1'b0);
        chk("t1 rst addr", 32'(mem_addr), 32'd0);
        reset  = 1'b1;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk("t1 restart addr", 32'(mem_addr), 32'd0);
        chk("t1 restart busy", 32'(busy), 32'd1);
        step();
        step();
        chk("t1 restart led", 32'(led), 32'(oh(c2[0])));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t1 abort busy", 32'(busy), 32'd0);

        // Full three-colour run with start/length noise while busy
        start  = 1'b1;
        length = 6'd3;
        for (int j = 0; j < 26; j++) begin
            string tag;
            step();
            tag = $sformatf("t2 j=%0d", j);
            chk_all(tag, vecs[j].led, vecs[j].busy, vecs[j].done);
            chk({tag, " addr"}, 32'(mem_addr), 32'(vecs[j].addr));
            start  = vecs[j].start;
            length = vecs[j].length;
        end
        start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            chk_all($sformatf("t2 tail %0d", j), 4'b0000, 1'b0, 1'b0);
        end

        // Zero-length playback
        length = 6'd0;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk_all("t3 j=0", 4'b0000, 1'b1, 1'b0);
        chk("t3 j=0 addr", 32'(mem_addr), 32'd2);
        step();
        chk_all("t3 j=1", 4'b0000, 1'b1, 1'b1);
        step();
        chk_all("t3 j=2", 4'b0000, 1'b0, 1'b0);
        chk("t3 j=2 addr", 32'(mem_addr), 32'd2);

        // Abort during the second ON phase
        length = 6'd3;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int j = 1; j <= 11; j++) step();
        chk("t4 pre led", 32'(led), 32'(oh(c2[1])));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_all("t4 aborted", 4'b0000, 1'b0, 1'b0);
        done_cnt = 0;
        for (int j = 0; j < 30; j++) begin
            step();
            if (done || busy || led != 4'b0000) done_cnt++;
        end
        chk("t4 quiet after abort", 32'(done_cnt), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4 replay addr", 32'(mem_addr), 32'd0);
        step();
        step();
        chk("t4 replay led", 32'(led), 32'(oh(c2[0])));
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Over-long length saturates at MAX_LEN
        for (int i = 0; i < 32; i++) ram[i] = 2'(i ^ (i >> 2));
        length = 6'd40;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 258; j++) begin
            string tag;
            int e;
            int p;
            if (j > 0) step();
            e = j / 8;
            p = j % 8;
            tag = $sformatf("t6 j=%0d", j);
            if (j < 256) begin
                chk_all(tag, (p >= 2 && p <= 5) ? oh(ram[e]) : 4'b0000,
                        1'b1, 1'b0);
                chk({tag, " addr"}, 32'(mem_addr), 32'(e));
            end else begin
                chk_all(tag, 4'b0000, (j == 256), (j == 256));
                chk({tag, " addr"}, 32'(mem_addr), 32'd31);
            end
        end

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk_all("t6 start+abort", 4'b0000, 1'b0, 1'b0);
        step();
        chk_all("t6 start+abort+1", 4'b0000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
